// File: rtl/configs_loader_pkg.sv
// Shared types and constants for the config loader and its word bank.
// Optional readback port is enabled with CONFIGS_LOADER_READBACK_EN.
package configs_loader_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int NUM_WORDS_DEF = 41;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Address width for n words; never narrower than one bit.
  function automatic int calc_addr_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/configs_word_bank.sv
// NUM_WORDS x DATA_W flopped config register array with flat image output.
// CONFIGS_LOADER_READBACK_EN adds a registered read port.
module configs_word_bank
  import configs_loader_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int ADDR_W    = calc_addr_w(NUM_WORDS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
`ifdef CONFIGS_LOADER_READBACK_EN
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [DATA_W-1:0]           rd_data,
`endif
  output logic [DATA_W*NUM_WORDS-1:0] words
);

  logic [DATA_W-1:0] word_reg [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_WORDS; i++) word_reg[i] <= '0;
    end else if (wr_en && (int'(wr_addr) < NUM_WORDS)) begin
      word_reg[wr_addr] <= wr_data;
    end
  end

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_flat
    assign words[gi*DATA_W +: DATA_W] = word_reg[gi];
  end

`ifdef CONFIGS_LOADER_READBACK_EN
  logic [DATA_W-1:0] rd_data_reg;

  // Read samples the pre-write contents, so a same-cycle write is not seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_reg <= '0;
    end else if (int'(rd_addr) < NUM_WORDS) begin
      rd_data_reg <= word_reg[rd_addr];
    end else begin
      rd_data_reg <= '0;
    end
  end

  assign rd_data = rd_data_reg;
`endif

endmodule

// File: rtl/configs_loader.sv
// Streams config words over valid/ready into an auto-addressed register bank.
// CONFIGS_LOADER_READBACK_EN adds io_rd_addr / io_rd_data.
module configs_loader
  import configs_loader_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int ADDR_W    = calc_addr_w(NUM_WORDS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        io_start,
  input  logic [ADDR_W-1:0]           io_start_addr,
  input  logic                        io_d_in_valid,
  output logic                        io_d_in_ready,
  input  logic [DATA_W-1:0]           io_d_in,
  output logic [DATA_W*NUM_WORDS-1:0] io_configs_out,
  output logic                        io_busy,
  output logic                        io_done,
  output logic                        io_configs_valid,
  output logic [ADDR_W:0]             io_word_cnt,
`ifdef CONFIGS_LOADER_READBACK_EN
  input  logic [ADDR_W-1:0]           io_rd_addr,
  output logic [DATA_W-1:0]           io_rd_data,
`endif
  output logic                        io_err
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W:0]   word_cnt_reg;
  logic              configs_valid_reg;
  logic              err_reg;
  logic              start_ok, start_bad, accept, last_word;

  assign start_ok  = io_start && (int'(io_start_addr) < NUM_WORDS);
  assign start_bad = io_start && !start_ok;
  // Start wins over a word presented in the same cycle.
  assign accept    = (state_reg == LOAD) && io_d_in_valid && !io_start;
  assign last_word = (int'(addr_reg) == NUM_WORDS - 1);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start_ok) state_next = LOAD;
      LOAD: begin
        if (start_bad)                 state_next = IDLE;
        else if (start_ok)             state_next = LOAD;
        else if (accept && last_word)  state_next = DONE;
      end
      DONE:    state_next = start_ok ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    io_d_in_ready = 1'b0;
    io_busy       = 1'b0;
    io_done       = 1'b0;
    case (state_reg)
      LOAD: begin
        io_d_in_ready = 1'b1;
        io_busy       = 1'b1;
      end
      DONE:    io_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg          <= '0;
      word_cnt_reg      <= '0;
      configs_valid_reg <= 1'b0;
      err_reg           <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_reg     <= io_start_addr;
        word_cnt_reg <= '0;
      end else if (accept) begin
        addr_reg     <= addr_reg + ADDR_W'(1);
        word_cnt_reg <= word_cnt_reg + (ADDR_W+1)'(1);
      end
      if (start_ok)                configs_valid_reg <= 1'b0;
      else if (state_reg == DONE)  configs_valid_reg <= 1'b1;
      // Error sources take precedence over the clear from a good start.
      if (start_bad || (io_d_in_valid && state_reg != LOAD)) err_reg <= 1'b1;
      else if (start_ok)                                      err_reg <= 1'b0;
    end
  end

  assign io_word_cnt      = word_cnt_reg;
  assign io_configs_valid = configs_valid_reg;
  assign io_err           = err_reg;

  configs_word_bank #(
    .DATA_W   (DATA_W),
    .NUM_WORDS(NUM_WORDS),
    .ADDR_W   (ADDR_W)
  ) u_bank (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (accept),
    .wr_addr(addr_reg),
    .wr_data(io_d_in),
`ifdef CONFIGS_LOADER_READBACK_EN
    .rd_addr(io_rd_addr),
    .rd_data(io_rd_data),
`endif
    .words  (io_configs_out)
  );

endmodule

// File: tb/tb_configs_loader.sv
// Scoreboard bench for configs_loader: random loads against an array model.
// Readback checks are built when CONFIGS_LOADER_READBACK_EN is defined.
module tb_configs_loader;

  localparam int DW    = 32;
  localparam int NW    = 41;
  localparam int AW    = $clog2(NW);
  localparam int IMG_W = DW * NW;

  typedef struct packed {
    logic [IMG_W-1:0] img;
    logic [AW:0]      cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             io_start = 1'b0;
  logic [AW-1:0]    io_start_addr = '0;
  logic             io_d_in_valid = 1'b0;
  logic             io_d_in_ready;
  logic [DW-1:0]    io_d_in = '0;
  logic [IMG_W-1:0] io_configs_out;
  logic             io_busy, io_done, io_configs_valid, io_err;
  logic [AW:0]      io_word_cnt;
`ifdef CONFIGS_LOADER_READBACK_EN
  logic [AW-1:0]    io_rd_addr = '0;
  logic [DW-1:0]    io_rd_data;
`endif

  configs_loader dut (
    .clk             (clk),
    .reset           (reset),
    .io_start        (io_start),
    .io_start_addr   (io_start_addr),
    .io_d_in_valid   (io_d_in_valid),
    .io_d_in_ready   (io_d_in_ready),
    .io_d_in         (io_d_in),
    .io_configs_out  (io_configs_out),
    .io_busy         (io_busy),
    .io_done         (io_done),
    .io_configs_valid(io_configs_valid),
    .io_word_cnt     (io_word_cnt),
`ifdef CONFIGS_LOADER_READBACK_EN
    .io_rd_addr      (io_rd_addr),
    .io_rd_data      (io_rd_data),
`endif
    .io_err          (io_err)
  );

  always #5 clk = ~clk;

  // Reference model: the image as an array plus a write pointer.
  logic [DW-1:0] img [NW];
  int            mdl_addr = 0;
  int            mdl_cnt = 0;
  exp_t          exp_q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  int            ready_cycles = 0;
  bit            valid_chk_pending = 0;

  function automatic logic [IMG_W-1:0] flat();
    logic [IMG_W-1:0] r;
    for (int i = 0; i < NW; i++) r[i*DW +: DW] = img[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_img(input string name, input logic [IMG_W-1:0] req);
    int bad;
    checks++;
    if (io_configs_out !== req) begin
      errors++;
      bad = 0;
      for (int i = NW - 1; i >= 0; i--)
        if (io_configs_out[i*DW +: DW] !== req[i*DW +: DW]) bad = i;
      $display("FAIL %s: word %0d got 0x%0h, expected 0x%0h", name, bad,
               io_configs_out[bad*DW +: DW], req[bad*DW +: DW]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_img({tag, "_image"}, '0);
    check({tag, "_ready"}, io_d_in_ready, 0);
    check({tag, "_busy"}, io_busy, 0);
    check({tag, "_done"}, io_done, 0);
    check({tag, "_configs_valid"}, io_configs_valid, 0);
    check({tag, "_word_cnt"}, io_word_cnt, 0);
    check({tag, "_err"}, io_err, 0);
  endtask

  task automatic start_pulse(input int a, input bit with_word, input logic [DW-1:0] d);
    io_start      = 1'b1;
    io_start_addr = AW'(a);
    io_d_in_valid = with_word;
    io_d_in       = d;
    tick();
    io_start      = 1'b0;
    io_d_in_valid = 1'b0;
    if (a < NW) begin
      mdl_addr = a;
      mdl_cnt  = 0;
    end
  endtask

  task automatic send_word(input logic [DW-1:0] d, input bit gaps);
    bit acc;
    int budget;
    acc = 0;
    budget = 0;
    while (!acc && budget < 200) begin
      io_d_in       = d;
      io_d_in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (io_d_in_ready) ready_cycles++;
      acc = io_d_in_valid && io_d_in_ready;
      tick();
      budget++;
    end
    io_d_in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_word_timeout: not accepted in %0d cycles, expected acceptance", budget);
    end else if (mdl_addr < NW) begin
      img[mdl_addr] = d;
      mdl_addr++;
      mdl_cnt++;
      if (mdl_addr == NW) begin
        exp_q.push_back('{img: flat(), cnt: (AW+1)'(mdl_cnt)});
        tick();
      end
    end
  endtask

  // pattern 0: 0xA5000000+index, 1: 0x11*(n+1), otherwise random
  task automatic run_load(input int start, input bit gaps, input int pattern);
    logic [DW-1:0] d;
    start_pulse(start, 0, '0);
    for (int i = start; i < NW; i++) begin
      if (pattern == 0)      d = 32'hA500_0000 + DW'(i);
      else if (pattern == 1) d = 32'h11 * DW'(i - start + 1);
      else                   d = $urandom();
      send_word(d, gaps);
    end
  endtask

  // Monitor: every io_done pops one expected completed image.
  always @(negedge clk) begin
    if (valid_chk_pending) begin
      check("configs_valid_after_done", io_configs_valid, 1);
      valid_chk_pending = 0;
    end
    if (!reset && io_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: io_done=1 with no load completed, expected 0");
      end else begin
        mon_e = exp_q.pop_front();
        check_img("done_image", mon_e.img);
        check("done_word_cnt", io_word_cnt, mon_e.cnt);
        check("done_busy", io_busy, 0);
        check("done_ready", io_d_in_ready, 0);
        valid_chk_pending = 1;
      end
    end
  end

  initial begin
    logic [DW-1:0] x, y;
    for (int i = 0; i < NW; i++) img[i] = '0;

    repeat (3) tick();
    reset = 1'b0;
    check_reset_values("reset");

    // Stray valid in IDLE
    io_d_in_valid = 1'b1;
    io_d_in       = 32'hDEAD_BEEF;
    tick();
    io_d_in_valid = 1'b0;
    check("idle_valid_err", io_err, 1);
    check_img("idle_valid_image", flat());

    // Full load, valid held high
    start_pulse(0, 0, '0);
    check("start_clears_err", io_err, 0);
    check("start_busy", io_busy, 1);
    check("start_word_cnt", io_word_cnt, 0);
    ready_cycles = 0;
    for (int i = 1; i <= NW; i++) begin
      send_word(32'hA500_0000 + DW'(i - 1), 0);
      if (i == NW - 1) check("cnt_before_last", io_word_cnt, NW - 1);
    end
    check("full_ready_cycles", ready_cycles, NW);
    check("full_word40", io_configs_out[40*DW +: DW], 32'hA500_0028);
`ifdef CONFIGS_LOADER_READBACK_EN
    io_rd_addr = 5;
    tick();
    check("rd_word5", io_rd_data, img[5]);
    io_rd_addr = 50;
    tick();
    check("rd_out_of_range", io_rd_data, 0);
`endif

    // Out-of-range start
    start_pulse(NW, 0, '0);
    check("bad_start_err", io_err, 1);
    check("bad_start_busy", io_busy, 0);
    tick();
    check("bad_start_still_idle", io_busy, 0);
    check("bad_start_valid_kept", io_configs_valid, 1);
    check_img("bad_start_image", flat());

    // Partial reload of the last three words
    run_load(38, 0, 1);
    check_img("partial_image", flat());

    // Gapped full load
    run_load(0, 1, 0);

    // Abort at addr 10 with a word on the bus
    start_pulse(0, 0, '0);
    for (int i = 0; i < 10; i++) send_word($urandom(), 1);
    x = ~img[10];
    start_pulse(0, 1, x);
    check("abort_word10_kept", io_configs_out[10*DW +: DW], img[10]);
    check("abort_configs_valid", io_configs_valid, 0);
    check("abort_word_cnt", io_word_cnt, 0);
    check("abort_busy", io_busy, 1);
    y = $urandom();
    send_word(y, 0);
    check("abort_word0", io_configs_out[0 +: DW], y);
    check("abort_valid_mid", io_configs_valid, 0);
    for (int i = 1; i < NW; i++) send_word($urandom(), 1);

    // Random partial loads
    for (int k = 0; k < 4; k++) run_load($urandom_range(0, NW - 1), $urandom_range(0, 1) == 1, 2);

    // Reset in the middle of a load
    start_pulse(0, 0, '0);
    for (int i = 0; i < 20; i++) send_word($urandom(), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NW; i++) img[i] = '0;
    mdl_addr = 0;
    mdl_cnt  = 0;
    check_reset_values("midload_reset");

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
